// File: rtl/sample_streamer.sv
// -----------------------------------------------------------------------------
// sample_streamer
//
// Consumer end of a generate_next / sample_ready sample handshake. A small
// request FSM asks the sample source for one sample at a time and keeps a
// DEPTH-entry FIFO topped up. A serializer pops one sample per frame and sends
// it MSB-first on a left-justified stereo serial DAC link (bclk/lrck/sdata).
// The same word goes out in both the left and the right slot (mono
// duplicated).
//
// Parameters
//   SAMPLE_W  sample width, which is also the number of bits per channel slot
//   DEPTH     FIFO depth in samples (power of 2, >= 2)
//   CLK_DIV   clk cycles per bclk half-period (>= 2)
//
// Ports
//   clk            system clock; all logic runs on the rising edge
//   reset          asynchronous, active-low reset
//   enable         1 = request samples and run the serial link
//   generate_next  one-cycle request pulse to the sample source
//   sample_ready   one-cycle pulse from the source; sample is valid with it
//   sample         two's-complement sample from the source
//   bclk           serial bit clock
//   lrck           channel select: 0 = left slot, 1 = right slot
//   sdata          serial data, MSB first, changes on bclk falling edges
//   fifo_level     number of samples buffered (registered)
//   underflow      sticky: a frame started while the FIFO was empty
//   protocol_err   sticky: sample_ready arrived with no request pending
// -----------------------------------------------------------------------------
module sample_streamer #(
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 4,
    parameter int CLK_DIV  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    output logic                      generate_next,
    input  logic                      sample_ready,
    input  logic [SAMPLE_W-1:0]       sample,
    output logic                      bclk,
    output logic                      lrck,
    output logic                      sdata,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      underflow,
    output logic                      protocol_err
);

    localparam int PTR_W      = $clog2(DEPTH);
    localparam int LVL_W      = PTR_W + 1;
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int FRAME_BITS = 2 * SAMPLE_W;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    // -------------------------------------------------------------------------
    // Request FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } req_state_t;

    req_state_t state;
    req_state_t state_next;

    logic pending;
    logic can_request;
    logic push;
    logic pop;

    // A request counts as pending from the pulse until its sample arrives, so
    // buffered plus in-flight samples can never exceed the FIFO depth.
    assign pending     = (state != S_IDLE);
    assign can_request = (fifo_level + LVL_W'(pending)) < LVL_W'(DEPTH);

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_next    = state;
        generate_next = 1'b0;
        push          = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable && can_request) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                generate_next = 1'b1;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                // Stays here even if enable drops: the sample already asked
                // for is still accepted.
                if (sample_ready) begin
                    push       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // A sample that arrives outside WAIT is dropped and flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            protocol_err <= 1'b0;
        end else if (sample_ready && (state != S_WAIT)) begin
            protocol_err <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Sample FIFO
    // -------------------------------------------------------------------------
    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [SAMPLE_W-1:0] head;

    // NOTE: the storage array has no reset; the level counter alone decides
    // which entries are valid, so clearing the data would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A push and a
    // pop in the same cycle both happen and leave the level unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // An empty FIFO at frame start turns into a frame of zeros.
    assign head = (fifo_level != '0) ? mem[rd_ptr] : '0;

    // -------------------------------------------------------------------------
    // Serial link
    // -------------------------------------------------------------------------
    logic                running;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] shreg;

    logic div_wrap;
    logic bclk_fall;
    logic frame_last;
    logic frame_start;

    assign div_wrap   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bclk_fall  = running && div_wrap && bclk;
    assign frame_last = (bit_cnt == BIT_W'(FRAME_BITS - 1));

    // A frame starts when the idle link is enabled, or at the bclk fall that
    // ends the right slot's LSB while enable is still high.
    assign frame_start = enable && (!running || (bclk_fall && frame_last));
    assign pop         = frame_start && (fifo_level != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
            sdata   <= 1'b0;
            word    <= '0;
            shreg   <= '0;
        end else if (frame_start) begin
            // Left-slot start: lrck and the MSB appear in the same cycle and
            // bclk begins its low half-period.
            running <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
            sdata   <= head[SAMPLE_W-1];
            word    <= head;
            shreg   <= {head[SAMPLE_W-2:0], 1'b0};
        end else if (running) begin
            if (div_wrap) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
                if (bclk) begin
                    // Falling edge: the only place lrck and sdata change.
                    if (frame_last) begin
                        // Frame over with enable low: park the link cleared.
                        running <= 1'b0;
                        bit_cnt <= '0;
                        lrck    <= 1'b0;
                        sdata   <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_W'(SAMPLE_W - 1)) begin
                            // Right slot re-sends the saved word MSB-first.
                            lrck  <= 1'b1;
                            sdata <= word[SAMPLE_W-1];
                            shreg <= {word[SAMPLE_W-2:0], 1'b0};
                        end else begin
                            sdata <= shreg[SAMPLE_W-1];
                            shreg <= {shreg[SAMPLE_W-2:0], 1'b0};
                        end
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underflow <= 1'b0;
        end else if (frame_start && (fifo_level == '0)) begin
            underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sample_streamer.sv
// -----------------------------------------------------------------------------
// tb_sample_streamer
//
// Self-checking bench for sample_streamer. A sample source model answers
// generate_next pulses. A frame-level reference model keeps a queue of
// accepted samples and predicts every serial bit seen at bclk rising edges,
// along with lrck, fifo_level and the sticky flags.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sample_streamer;

    localparam int SAMPLE_W   = 16;
    localparam int DEPTH      = 4;
    localparam int CLK_DIV    = 4;
    localparam int FRAME_BITS = 2 * SAMPLE_W;
    localparam int FRAME_CYC  = FRAME_BITS * 2 * CLK_DIV;
    localparam int LVL_W      = $clog2(DEPTH) + 1;
    localparam int NVEC       = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                sample_ready;
    logic [SAMPLE_W-1:0] sample;
    logic                generate_next;
    logic                bclk;
    logic                lrck;
    logic                sdata;
    logic [LVL_W-1:0]    fifo_level;
    logic                underflow;
    logic                protocol_err;

    sample_streamer #(
        .SAMPLE_W(SAMPLE_W),
        .DEPTH   (DEPTH),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .generate_next(generate_next),
        .sample_ready (sample_ready),
        .sample       (sample),
        .bclk         (bclk),
        .lrck         (lrck),
        .sdata        (sdata),
        .fifo_level   (fifo_level),
        .underflow    (underflow),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;
    int cyc   = 0;   // negedge count; posedge number n precedes negedge n

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [SAMPLE_W-1:0] word;
        logic [127:0]        bits;   // 16 ASCII '0'/'1', MSB first
    } vec_t;
    vec_t vecs [NVEC];

    // ---------------- reference model ----------------
    typedef struct {
        int                  push_cyc;
        logic [SAMPLE_W-1:0] value;
    } push_t;

    push_t                 mq[$];
    logic [SAMPLE_W-1:0]   pushed_log[$];
    logic [FRAME_BITS-1:0] cap_q[$];
    logic [FRAME_BITS-1:0] cap_bits;
    logic [SAMPLE_W-1:0]   frame_word;
    int  outstanding;
    int  pulses;
    int  countdown;
    int  budget;          // answers allowed; -1 = unlimited
    int  dly_min;
    int  dly_max;
    int  long_pct;
    int  vec_ptr;
    bit  use_table;
    bit  exp_perr;
    bit  exp_uf;
    bit  prev_bclk;
    bit  prev_gen;
    int  link_idx;
    int  last_rise;
    int  frame_start_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_level();
        int n = 0;
        foreach (mq[i]) if (mq[i].push_cyc <= cyc) n++;
        return n;
    endfunction

    function automatic int pick_delay();
        if (long_pct > 0 && $urandom_range(99, 0) < long_pct)
            return $urandom_range(400, 100);
        return $urandom_range(dly_max, dly_min);
    endfunction

    task automatic clear_model();
        mq.delete();
        pushed_log.delete();
        cap_q.delete();
        cap_bits        = '0;
        frame_word      = '0;
        outstanding     = 0;
        pulses          = 0;
        countdown       = 0;
        exp_perr        = 1'b0;
        exp_uf          = 1'b0;
        prev_bclk       = 1'b0;
        prev_gen        = 1'b0;
        link_idx        = 0;
        last_rise       = 0;
        frame_start_cyc = -1;
        vec_ptr         = 0;
    endtask

    // Drive one source answer; it counts as accepted only if a request is
    // outstanding, and lands in the DUT at the next posedge.
    task automatic answer(input logic [SAMPLE_W-1:0] v);
        sample_ready = 1'b1;
        sample       = v;
        if (outstanding > 0) begin
            outstanding--;
            mq.push_back('{push_cyc: cyc + 1, value: v});
            pushed_log.push_back(v);
        end else begin
            exp_perr = 1'b1;
        end
    endtask

    function automatic logic [SAMPLE_W-1:0] next_value();
        logic [SAMPLE_W-1:0] v;
        if (use_table && vec_ptr < NVEC) begin
            v = vecs[vec_ptr].word;
            vec_ptr++;
        end else begin
            v = SAMPLE_W'($urandom);
        end
        return v;
    endfunction

    task automatic observe();
        int f;
        if (generate_next) begin
            check("gen_one_cycle", prev_gen, 1'b0);
            check("gen_single_outstanding", outstanding, 0);
            outstanding++;
            pulses++;
            countdown = pick_delay();
        end
        prev_gen = generate_next;

        if (bclk && !prev_bclk) begin
            if (link_idx == 0) begin
                // This rise belongs to a frame that started CLK_DIV cycles ago;
                // the FIFO then held only samples pushed before that edge.
                f = cyc - CLK_DIV;
                frame_start_cyc = f;
                if (mq.size() > 0 && mq[0].push_cyc < f) begin
                    frame_word = mq[0].value;
                    void'(mq.pop_front());
                end else begin
                    frame_word = '0;
                    exp_uf     = 1'b1;
                end
                cap_bits = '0;
            end else begin
                check("bit_period", cyc - last_rise, 2 * CLK_DIV);
            end
            check("sdata", sdata, frame_word[SAMPLE_W-1-(link_idx % SAMPLE_W)]);
            check("lrck", lrck, (link_idx >= SAMPLE_W));
            check("underflow", underflow, exp_uf);
            check("fifo_level", fifo_level, model_level());
            check("protocol_err", protocol_err, exp_perr);
            cap_bits[FRAME_BITS-1-link_idx] = sdata;
            last_rise = cyc;
            link_idx++;
            if (link_idx == FRAME_BITS) begin
                link_idx = 0;
                cap_q.push_back(cap_bits);
            end
        end
        prev_bclk = bclk;
    endtask

    task automatic drive_source();
        sample_ready = 1'b0;
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0 && budget != 0) begin
                if (budget > 0) budget--;
                answer(next_value());
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        observe();
        drive_source();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input bit en_after);
        reset        = 1'b0;
        enable       = 1'b0;
        sample_ready = 1'b0;
        sample       = '0;
        repeat (2) begin
            @(negedge clk);
            cyc++;
        end
        check("reset_outputs",
              {generate_next, bclk, lrck, sdata, underflow, protocol_err, fifo_level}, '0);
        clear_model();
        reset  = 1'b1;
        enable = en_after;
    endtask

    task automatic wait_frames(input string name, input int n);
        int start = cap_q.size();
        int k     = 0;
        while (cap_q.size() < start + n && k < (n + 1) * FRAME_CYC) begin
            tick();
            k++;
        end
        check(name, cap_q.size() >= start + n, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FRAME_BITS-1:0] fr;
        logic [SAMPLE_W-1:0]   exp_w;
        int viol;
        int k;
        logic [SAMPLE_W-1:0] v;

        vecs[0] = '{word: 16'hA5C3, bits: "1010010111000011"};
        vecs[1] = '{word: 16'h8000, bits: "1000000000000000"};
        vecs[2] = '{word: 16'h0001, bits: "0000000000000001"};
        vecs[3] = '{word: 16'hFFFF, bits: "1111111111111111"};
        vecs[4] = '{word: 16'h7FFE, bits: "0111111111111110"};

        budget    = -1;
        dly_min   = 3;
        dly_max   = 3;
        long_pct  = 0;
        use_table = 1'b0;
        clear_model();

        // ---- reset state, link idle with enable low ----
        do_reset(1'b0);
        run(20);
        check("idle_no_request", pulses, 0);
        check("idle_bclk_low", bclk, 1'b0);

        // ---- sample_ready while idle: dropped, protocol_err set ----
        answer(16'h1234);
        tick();
        check("perr_set", protocol_err, 1'b1);
        check("perr_level_unchanged", fifo_level, 0);
        run(5);
        check("perr_sticky", protocol_err, 1'b1);

        // ---- source never answers: one pulse, zero frame, underflow ----
        do_reset(1'b1);
        budget = 0;
        run(FRAME_CYC + 20);
        check("silent_one_pulse", pulses, 1);
        check("silent_frame_count", cap_q.size() >= 1, 1'b1);
        check("silent_frame_zero", (cap_q.size() > 0) ? cap_q[0] : '1, '0);
        check("silent_underflow", underflow, 1'b1);

        // ---- fill to DEPTH with 3-cycle answers, then table words ----
        do_reset(1'b1);
        budget    = -1;
        use_table = 1'b1;
        run(200);
        check("fill_pulses", pulses, DEPTH);
        check("fill_level", fifo_level, DEPTH);
        wait_frames("table_frames_timeout", NVEC + 1 - cap_q.size());
        if (cap_q.size() >= NVEC + 1) begin
            check("table_frame0_zero", cap_q[0], '0);
            for (int i = 0; i < NVEC; i++) begin
                for (int b = 0; b < SAMPLE_W; b++)
                    exp_w[SAMPLE_W-1-b] = (vecs[i].bits[8*(SAMPLE_W-b)-1 -: 8] == 8'h31);
                fr = cap_q[i+1];
                check($sformatf("table_left_%0d", i), fr[FRAME_BITS-1 -: SAMPLE_W], exp_w);
                check($sformatf("table_right_%0d", i), fr[SAMPLE_W-1:0], exp_w);
            end
        end
        use_table = 1'b0;

        // ---- push and pop in the same cycle at level 2 ----
        do_reset(1'b1);
        budget = 2;
        k = 0;
        while (frame_start_cyc < 0 && k < 20) begin
            tick();
            k++;
        end
        check("pp_link_started", frame_start_cyc >= 0, 1'b1);
        if (frame_start_cyc >= 0) begin
            while (cyc < frame_start_cyc + FRAME_CYC - 1) tick();
            check("pp_level_before", fifo_level, 2);
            check("pp_request_pending", outstanding, 1);
            budget = -1;
            v = SAMPLE_W'($urandom);
            answer(v);
            tick();
            check("pp_level_after", fifo_level, 2);
            wait_frames("pp_frames_timeout", 4 - cap_q.size());
            if (cap_q.size() >= 4 && pushed_log.size() >= 3) begin
                for (int i = 0; i < 3; i++)
                    check($sformatf("pp_order_%0d", i), cap_q[i+1], {pushed_log[i], pushed_log[i]});
            end
        end

        // ---- enable low: stop at frame boundary, keep buffered samples ----
        k = 0;
        while (link_idx != 5 && k < 2 * FRAME_CYC) begin
            tick();
            k++;
        end
        enable = 1'b0;
        k = 0;
        while (link_idx != 0 && k < 2 * FRAME_CYC) begin
            tick();
            k++;
        end
        run(2 * CLK_DIV);
        viol = 0;
        repeat (300) begin
            tick();
            if (bclk || lrck || sdata) viol++;
        end
        check("stop_link_quiet", viol, 0);
        check("stop_no_requests", generate_next, 1'b0);
        check("stop_level_kept", fifo_level, model_level());
        enable = 1'b1;
        wait_frames("restart_frames_timeout", 2);

        // ---- randomized traffic, including source stalls ----
        dly_min  = 2;
        dly_max  = 8;
        long_pct = 4;
        run(8 * FRAME_CYC);
        long_pct = 0;

        // ---- reset mid-frame with a request pending ----
        budget = 0;
        k = pulses;
        while (pulses == k && k < 1_000_000 && cyc < 60_000) tick();
        run(40);
        check("midreset_pending", outstanding, 1);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_outputs",
              {generate_next, bclk, lrck, sdata, underflow, protocol_err, fifo_level}, '0);
        @(negedge clk);
        cyc++;
        clear_model();
        budget       = -1;
        dly_min      = 3;
        dly_max      = 3;
        sample_ready = 1'b0;
        reset        = 1'b1;
        enable       = 1'b1;
        for (int i = 0; i < 2 && pulses == 0; i++) tick();
        check("midreset_gen_within_2", pulses, 1);
        run(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
